// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus gate arbiter.
// Requester indices match the bit positions of the req vector.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int N_REQ      = 4;
    localparam int REQ_PC     = 0;
    localparam int REQ_MDR    = 1;
    localparam int REQ_MARMUX = 2;
    localparam int REQ_ALU    = 3;

    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_gate_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping 3->0.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             valid,
    output logic [1:0]       idx
);

    logic [1:0] cand_s;

    // Rotating priority scan; the first hit wins and later hits are ignored.
    always_comb begin
        valid  = 1'b0;
        idx    = 2'd0;
        cand_s = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = ptr + 2'(k);
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                idx   = cand_s;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Round-robin owner sequencing for the shared datapath bus with registered one-hot Gate* enables.
// Optional tenure limit with forced release is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_gate_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int MAX_TENURE  = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_REQ-1:0] req,
    output logic             GatePC,
    output logic             GateMDR,
    output logic             GateMARMUX,
    output logic             GateALU,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             timeout
);

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gate_q, gate_d;
    logic [1:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]    turn_cnt_q, turn_cnt_d;

    logic             release_s;
    logic             force_s;
    logic             arb_en_s;
    logic [N_REQ-1:0] elig_s;
    logic             pick_valid_s;
    logic [1:0]       pick_idx_s;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TEN_W = $clog2(MAX_TENURE + 1);

    logic [TEN_W-1:0] tenure_q, tenure_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic             timeout_q, timeout_d;

    // Owner gives up the bus by dropping req, or is forced off once its tenure is used up.
    always_comb begin
        release_s = 1'b0;
        force_s   = 1'b0;
        if (state_q == GRANT) begin
            if (!req[owner_q]) begin
                release_s = 1'b1;
            end else if (tenure_q == TEN_W'(MAX_TENURE)) begin
                release_s = 1'b1;
                force_s   = 1'b1;
            end else begin
                release_s = 1'b0;
            end
        end else begin
            release_s = 1'b0;
        end
    end

    // A timed-out owner stays ineligible, including for a same-edge handover, until its req goes low.
    assign elig_s = req & ~mask_q & ~(force_s ? onehot4(owner_q) : 4'b0000);
`else
    // Without the tenure limit an owner only leaves by dropping its request.
    always_comb begin
        force_s = 1'b0;
        if (state_q == GRANT) begin
            release_s = !req[owner_q];
        end else begin
            release_s = 1'b0;
        end
    end

    assign elig_s = req;
`endif

    rr_pick u_rr_pick (
        .req   (elig_s),
        .ptr   (rr_ptr_q),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Next-state logic; gates are only ever set to zero or to a single freshly picked bit.
    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        turn_cnt_d = turn_cnt_q;
        arb_en_s   = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        tenure_d  = tenure_q;
        mask_d    = (mask_q & req) | (force_s ? onehot4(owner_q) : 4'b0000);
        timeout_d = force_s;
`endif
        case (state_q)
            IDLE: begin
                gate_d   = 4'b0000;
                arb_en_s = 1'b1;
            end
            GRANT: begin
                if (release_s) begin
                    gate_d = 4'b0000;
                    if (TURN_CYCLES > 0) begin
                        state_d    = TURN;
                        turn_cnt_d = TW'(TURN_CYCLES - 1);
                    end else begin
                        state_d  = IDLE;
                        arb_en_s = 1'b1;
                    end
                end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                    tenure_d = tenure_q + TEN_W'(1);
`endif
                    gate_d = gate_q;
                end
            end
            TURN: begin
                gate_d = 4'b0000;
                if (turn_cnt_q == TW'(0)) begin
                    state_d  = IDLE;
                    arb_en_s = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 4'b0000;
            end
        endcase

        if (arb_en_s && pick_valid_s) begin
            state_d  = GRANT;
            gate_d   = onehot4(pick_idx_s);
            owner_d  = pick_idx_s;
            rr_ptr_d = pick_idx_s + 2'd1;
`ifdef BUS_ARB_TIMEOUT_EN
            tenure_d = TEN_W'(1);
`endif
        end else begin
            owner_d = owner_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset clears the gates immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            gate_q     <= 4'b0000;
            owner_q    <= 2'd0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= 2'd0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Tenure counter, offender mask and timeout pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tenure_q  <= '0;
            mask_q    <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            tenure_q  <= tenure_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign GatePC     = gate_q[REQ_PC];
    assign GateMDR    = gate_q[REQ_MDR];
    assign GateMARMUX = gate_q[REQ_MARMUX];
    assign GateALU    = gate_q[REQ_ALU];
    assign owner      = owner_q;
    assign busy       = busy_q;

endmodule
